// File: rtl/lorenz_sampler.sv
// lorenz_sampler: decimates the Lorenz integrator x/y/z state stream, narrows
// each 64-bit fixed-point word to a saturated OUT_W-bit word, and buffers the
// triples in a show-ahead FIFO behind a valid/ready interface.
//
// Ports:
//   clk, reset            clock; synchronous active-low reset
//   x_in, y_in, z_in      integrator state words (SIZE bits, PNT fractional)
//   run                   integrator stepping; low holds the decimation count at 0
//   decim                 capture one sample every decim+1 cycles
//   clr                   clears overflow and drop_cnt (wins over a same-cycle drop)
//   out_valid/out_ready   FIFO head handshake
//   out_x, out_y, out_z   head sample (OUT_W bits, OUT_FRAC fractional)
//   level                 registered FIFO occupancy
//   overflow, drop_cnt    sticky drop flag and saturating drop counter
//   out_ts                strobe-cycle step count (only with LORENZ_SAMPLER_TS_EN)
//
// Optional feature macro: LORENZ_SAMPLER_TS_EN adds a 32-bit step counter whose
// value on each strobe cycle travels with the sample and appears on out_ts.
module lorenz_sampler #(
  parameter int unsigned SIZE     = 64,
  parameter int unsigned PNT      = 48,
  parameter int unsigned OUT_W    = 16,
  parameter int unsigned OUT_FRAC = 8,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned DIV_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [SIZE-1:0]          x_in,
  input  logic [SIZE-1:0]          y_in,
  input  logic [SIZE-1:0]          z_in,
  input  logic                     run,
  input  logic [DIV_W-1:0]         decim,
  input  logic                     clr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [OUT_W-1:0]         out_x,
  output logic [OUT_W-1:0]         out_y,
  output logic [OUT_W-1:0]         out_z,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
`ifdef LORENZ_SAMPLER_TS_EN
  output logic [31:0]              out_ts,
`endif
  output logic [15:0]              drop_cnt
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned SHIFT = PNT - OUT_FRAC;
`ifdef LORENZ_SAMPLER_TS_EN
  localparam int unsigned ENTRY_W = 3 * OUT_W + 32;
`else
  localparam int unsigned ENTRY_W = 3 * OUT_W;
`endif

  // Arithmetic shift (floor) then saturate to the signed OUT_W range.
  function automatic logic [OUT_W-1:0] narrow(input logic [SIZE-1:0] v);
    logic [SIZE-1:0] s;
    s = SIZE'($signed(v) >>> SHIFT);
    if ((&s[SIZE-1:OUT_W-1]) || !(|s[SIZE-1:OUT_W-1]))
      narrow = s[OUT_W-1:0];
    else if (s[SIZE-1])
      narrow = {1'b1, {(OUT_W-1){1'b0}}};
    else
      narrow = {1'b0, {(OUT_W-1){1'b1}}};
  endfunction

  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic               cap_vld_q, cap_vld_d;
  logic [ENTRY_W-1:0] cap_data_q, cap_data_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [AW:0]        level_q, level_d;
  logic [ENTRY_W-1:0] head_q, head_d;
  logic               overflow_q, overflow_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;
  logic [ENTRY_W-1:0] mem_q [DEPTH];
`ifdef LORENZ_SAMPLER_TS_EN
  logic [31:0]        ts_q, ts_d;
`endif

  logic        strobe_c, pop_c, full_c, wr_en_c, drop_c;
  logic [AW:0] count_c;

  // Next-state logic for decimation, capture stage, FIFO control and status.
  always_comb begin
    cnt_d       = cnt_q;
    cap_vld_d   = 1'b0;
    cap_data_d  = cap_data_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    head_d      = head_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;
`ifdef LORENZ_SAMPLER_TS_EN
    ts_d        = run ? ts_q + 32'd1 : ts_q;
`endif

    strobe_c = run && (cnt_q == decim);
    if (!run)
      cnt_d = '0;
    else if (strobe_c)
      cnt_d = '0;
    else
      cnt_d = cnt_q + DIV_W'(1);

    if (strobe_c) begin
      cap_vld_d = 1'b1;
`ifdef LORENZ_SAMPLER_TS_EN
      cap_data_d = {ts_q, narrow(x_in), narrow(y_in), narrow(z_in)};
`else
      cap_data_d = {narrow(x_in), narrow(y_in), narrow(z_in)};
`endif
    end

    // Pop only on a valid head; a full FIFO still accepts a push alongside a pop.
    count_c = wr_ptr_q - rd_ptr_q;
    full_c  = (count_c == (AW+1)'(DEPTH));
    pop_c   = out_valid_q && out_ready;
    wr_en_c = cap_vld_q && (!full_c || pop_c);
    drop_c  = cap_vld_q && full_c && !pop_c;

    rd_ptr_d    = rd_ptr_q + (AW+1)'(pop_c);
    wr_ptr_d    = wr_ptr_q + (AW+1)'(wr_en_c);
    level_d     = wr_ptr_d - rd_ptr_d;
    out_valid_d = (level_d != '0);

    // Registered show-ahead head; a push into an emptying slot forwards directly.
    if (level_d != '0) begin
      if (wr_en_c && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0]))
        head_d = cap_data_q;
      else
        head_d = mem_q[rd_ptr_d[AW-1:0]];
    end

    if (clr) begin
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else if (drop_c) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != 16'hFFFF)
        drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q       <= '0;
      cap_vld_q   <= 1'b0;
      cap_data_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      level_q     <= '0;
      head_q      <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
`ifdef LORENZ_SAMPLER_TS_EN
      ts_q        <= '0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      cap_vld_q   <= cap_vld_d;
      cap_data_q  <= cap_data_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      level_q     <= level_d;
      head_q      <= head_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
`ifdef LORENZ_SAMPLER_TS_EN
      ts_q        <= ts_d;
`endif
    end
  end

  // FIFO storage; contents are don't-care once reset clears the pointers.
  always_ff @(posedge clk) begin
    if (wr_en_c)
      mem_q[wr_ptr_q[AW-1:0]] <= cap_data_q;
  end

  assign out_valid = out_valid_q;
  assign out_x     = head_q[3*OUT_W-1:2*OUT_W];
  assign out_y     = head_q[2*OUT_W-1:OUT_W];
  assign out_z     = head_q[OUT_W-1:0];
  assign level     = level_q;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;
`ifdef LORENZ_SAMPLER_TS_EN
  assign out_ts    = head_q[ENTRY_W-1:3*OUT_W];
`endif

endmodule

// File: tb/tb_lorenz_sampler.sv
module tb_lorenz_sampler;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] x_in, y_in, z_in;
  logic        run;
  logic [15:0] decim;
  logic        clr;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_x, out_y, out_z;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;
`ifdef LORENZ_SAMPLER_TS_EN
  logic [31:0] out_ts;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  lorenz_sampler dut (
    .clk       (clk),
    .reset     (reset),
    .x_in      (x_in),
    .y_in      (y_in),
    .z_in      (z_in),
    .run       (run),
    .decim     (decim),
    .clr       (clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_z     (out_z),
    .level     (level),
    .overflow  (overflow),
`ifdef LORENZ_SAMPLER_TS_EN
    .out_ts    (out_ts),
`endif
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] x, y, z;
    logic [15:0] ex, ey, ez;
  } conv_vec_t;

  conv_vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int got_x[$];
  int got_k[$];
  int exp_s[7];

  initial begin
    reset = 1'b0; run = 1'b0; decim = '0; clr = 1'b0; out_ready = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;

    vecs[0] = '{x: 64'h0001_0000_0000_0000, y: 64'hFFFD_8000_0000_0000, z: 64'h0,
                ex: 16'h0100, ey: 16'hFD80, ez: 16'h0000};
    vecs[1] = '{x: 64'h00C8_0000_0000_0000, y: 64'hFF38_0000_0000_0000, z: 64'h0,
                ex: 16'h7FFF, ey: 16'h8000, ez: 16'h0000};
    vecs[2] = '{x: 64'hFFFF_FFFF_FFFF_FFFF, y: 64'h007F_FF00_0000_0000, z: 64'h0080_0000_0000_0000,
                ex: 16'hFFFF, ey: 16'h7FFF, ez: 16'h7FFF};
    vecs[3] = '{x: 64'hFF80_0000_0000_0000, y: 64'h0000_00FF_FFFF_FFFF, z: 64'hFFFF_FEFF_FFFF_FFFF,
                ex: 16'h8000, ey: 16'h0000, ez: 16'hFFFE};
    vecs[4] = '{x: 64'h8000_0000_0000_0000, y: 64'h7FFF_FFFF_FFFF_FFFF, z: 64'h0000_0180_0000_0000,
                ex: 16'h8000, ey: 16'h7FFF, ez: 16'h0001};
    exp_s = '{3, 7, 11, 15, 19, 28, 32};

    // Reset state
    step(); step();
    @(negedge clk);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    chk("rst_x", 32'(out_x), 0);
    chk("rst_y", 32'(out_y), 0);
    chk("rst_z", 32'(out_z), 0);
    step();
    reset = 1'b1;

    // Conversion / saturation vectors with exact 2-clock latency
    out_ready = 1'b1;
    decim = 16'd0;
    for (int i = 0; i < 5; i++) begin
      x_in = vecs[i].x; y_in = vecs[i].y; z_in = vecs[i].z; run = 1'b1;
      @(negedge clk);
      chk("conv_pre", 32'(out_valid), 0);
      step();
      run = 1'b0;
      @(negedge clk);
      chk("conv_lat1", 32'(out_valid), 0);
      step();
      @(negedge clk);
      chk("conv_valid", 32'(out_valid), 1);
      chk("conv_x", 32'(out_x), 32'(vecs[i].ex));
      chk("conv_y", 32'(out_y), 32'(vecs[i].ey));
      chk("conv_z", 32'(out_z), 32'(vecs[i].ez));
      step();
    end

    // Decimation by 4, with a run gap
    decim = 16'd3;
    y_in = '0; z_in = '0;
    for (int k = 0; k < 38; k++) begin
      x_in = 64'(k) << 48;
      run = (k < 20) || (k >= 25 && k <= 33);
      @(negedge clk);
      if (out_valid) begin
        got_x.push_back(int'(out_x));
        got_k.push_back(k);
      end
      step();
    end
    run = 1'b0;
    chk("decim_count", 32'(got_x.size()), 7);
    for (int i = 0; i < 7 && i < got_x.size(); i++) begin
      chk("decim_x", 32'(got_x[i]), 32'(exp_s[i] * 256));
      chk("decim_cycle", 32'(got_k[i]), 32'(exp_s[i] + 2));
    end

    // Overflow: 21 captures into a 16-deep FIFO with no consumer
    decim = 16'd0;
    out_ready = 1'b0;
    for (int k = 0; k < 21; k++) begin
      x_in = 64'(k + 1) << 48;
      run = 1'b1;
      step();
    end
    run = 1'b0;
    step(); step(); step();
    @(negedge clk);
    chk("ovf_level", 32'(level), 16);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_drops", 32'(drop_cnt), 5);
    chk("ovf_head", 32'(out_x), 32'h0100);
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    @(negedge clk);
    chk("clr_flag", 32'(overflow), 0);
    chk("clr_drops", 32'(drop_cnt), 0);
    chk("clr_level", 32'(level), 16);

    // Full FIFO with a pop alongside every push
    got_x.delete();
    x_in = 64'(100) << 48;
    run = 1'b1;
    out_ready = 1'b0;
    step();
    for (int k = 1; k <= 30; k++) begin
      x_in = 64'(100 + k) << 48;
      run = (k <= 10);
      out_ready = 1'b1;
      @(negedge clk);
      if (k >= 2 && k <= 12) chk("fullpop_level", 32'(level), 16);
      if (out_valid) got_x.push_back(int'(out_x));
      step();
    end
    chk("fullpop_count", 32'(got_x.size()), 27);
    for (int i = 0; i < 27 && i < got_x.size(); i++)
      chk("fullpop_order", 32'(got_x[i]), (i < 16) ? 32'((i + 1) * 256) : 32'((84 + i) * 256));
    @(negedge clk);
    chk("fullpop_drops", 32'(drop_cnt), 0);
    chk("fullpop_ovf", 32'(overflow), 0);
    chk("fullpop_empty_level", 32'(level), 0);
    chk("fullpop_empty_valid", 32'(out_valid), 0);
    chk("fullpop_hold_x", 32'(out_x), 32'h6E00);
    step();

    // Reset mid-stream with 7 samples buffered
    out_ready = 1'b0;
    for (int k = 0; k < 7; k++) begin
      x_in = 64'(50 + k) << 48;
      run = 1'b1;
      step();
    end
    run = 1'b0;
    step(); step();
    @(negedge clk);
    chk("pre_rst_level", 32'(level), 7);
    step();
    reset = 1'b0;
    step();
    @(negedge clk);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_drops", 32'(drop_cnt), 0);
    chk("mid_rst_x", 32'(out_x), 0);
    reset = 1'b1;
    step();
    x_in = 64'(3) << 48;
    run = 1'b1;
    out_ready = 1'b1;
    step();
    run = 1'b0;
    step();
    @(negedge clk);
    chk("post_rst_valid", 32'(out_valid), 1);
    chk("post_rst_level", 32'(level), 1);
    chk("post_rst_x", 32'(out_x), 32'h0300);
`ifdef LORENZ_SAMPLER_TS_EN
    chk("post_rst_ts", out_ts, 0);
`endif
    step();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/lorenz_sampler.md
Name: lorenz_sampler

Overview:
Downstream consumer of the Lorenz integrator's x/y/z state outputs.
- Decimates the per-clock state stream by a programmable ratio.
- Narrows each 64-bit fixed-point value to a saturated 16-bit display/DAC word.
- Buffers samples in a small FIFO behind a valid/ready interface for the VGA/DAC or bus-bridge consumer.

Parameters:
SIZE, 64, width of incoming state words (signed fixed point)
PNT, 48, fractional bits of incoming state words
OUT_W, 16, width of each output word (signed)
OUT_FRAC, 8, fractional bits of output words; requires OUT_FRAC <= PNT
DEPTH, 16, FIFO entries; must be a power of 2, at least 2
DIV_W, 16, width of decimation ratio input

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low
x_in  in  SIZE  integrator x state, valid every clock
y_in  in  SIZE  integrator y state
z_in  in  SIZE  integrator z state
run  in  1  high while integrator is stepping; low freezes capture
decim  in  DIV_W  capture one sample every decim+1 cycles
clr  in  1  synchronous clear of overflow and drop_cnt
out_valid  out  1  FIFO head valid
out_ready  in  1  consumer accepts head
out_x  out  OUT_W  head sample x
out_y  out  OUT_W  head sample y
out_z  out  OUT_W  head sample z
level  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky: at least one sample dropped
drop_cnt  out  16  dropped-sample count, saturates at 0xFFFF

Behaviour:
- Reset (reset==0 at posedge clk):
  - Decimation counter = 0; capture stage invalid; FIFO empty.
  - out_valid = 0, level = 0, overflow = 0, drop_cnt = 0.
  - out_x/out_y/out_z = 0.
  - Reset mid-operation discards all buffered samples.
- Decimation counter (cnt):
  - While run==0: cnt held at 0, no capture.
  - While run==1: capture strobe when cnt == decim, then cnt <= 0; otherwise cnt <= cnt+1.
  - decim==0: capture every cycle.
  - decim changed mid-count: new value is compared from the next cycle. If cnt > decim, the count continues and wraps through 2^DIV_W.
- Conversion:
  - Each captured word is arithmetically shifted right by PNT-OUT_FRAC (truncate toward minus infinity).
  - Result is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - x, y and z convert independently.
- Capture stage: converted triple registered on the strobe cycle; pushed into the FIFO on the following cycle. Sample latency from strobe edge to out_valid is 2 clocks.
- FIFO:
  - Storage: DEPTH x 3*OUT_W, read/write pointers with an extra wrap bit.
  - Show-ahead: out_x/y/z always reflect the head entry while out_valid==1.
  - While empty, outputs hold the last popped value, or 0 after reset.
  - Pop when out_valid && out_ready.
  - Push of a pending sample:
    - Not full: written.
    - Full with a simultaneous pop: written; level unchanged.
    - Full with no pop: sample dropped, overflow <= 1, drop_cnt increments unless at 0xFFFF.
  - Push and pop on an empty FIFO: the push is written and no pop occurs. out_valid rises on the next cycle.
  - level reflects post-update occupancy, registered.
- clr: clears overflow and drop_cnt. If clr coincides with a drop, clr wins and the drop is not counted.
- out_ready is ignored while out_valid==0.
- No combinational path from out_ready to out_valid or to data.

Optional Feature:
- Macro: LORENZ_SAMPLER_TS_EN
- Defined:
  - Adds output out_ts [31:0] and a 32-bit free-running step counter.
  - The step counter increments each cycle with run==1, wraps at 2^32, and is reset to 0.
  - Its value on the strobe cycle is stored alongside the sample and presented with the head entry.
  - FIFO width becomes 3*OUT_W+32.
- Undefined: out_ts port, step counter and extra storage are absent; all other behaviour is identical.

Test Plan:
1. Conversion: decim=0, run=1, out_ready=1. x_in=2^48 (1.0), y_in=-5*2^47 (-2.5), z_in=0 -> out_x=0x0100, out_y=0xFD80, out_z=0x0000, first out_valid exactly 2 clocks after the strobe edge.
2. Saturation: x_in=200*2^48, y_in=-200*2^48 -> out_x=0x7FFF, out_y=0x8000.
3. Decimation: decim=3, run=1 for 20 cycles, out_ready=1 -> exactly 5 samples at strobe cycles 3, 7, 11, 15, 19. Drop run for 5 cycles and resume -> next strobe 3 cycles after resume.
4. Overflow: decim=0, out_ready=0, run=1 for DEPTH+5 cycles -> level=16, overflow=1, drop_cnt=5 after the pipeline drains. Pulse clr -> overflow=0, drop_cnt=0, level stays 16.
5. Full with simultaneous pop: FIFO full, out_ready=1, decim=0 -> level stays 16, no drops, samples emerge in capture order.
6. Reset mid-stream: FIFO holding 7 samples, assert reset one cycle -> out_valid=0, level=0, drop_cnt=0. With LORENZ_SAMPLER_TS_EN, first post-reset sample shows out_ts=0 when run rises immediately with decim=0.
